// File: rtl/tt_c6_sum_uart_tx.sv
// Adds operand A and 7-bit operand B on a start edge and sends sum[7:0] as an 8N1 UART frame.
// Define SUMTX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module tt_c6_sum_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SUMTX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [11:0] BIT_LAST = 12'(CLKS_PER_BIT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_cnt;
    logic [11:0] w_cnt_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  r_sum;
    logic [7:0]  w_sum_nxt;
    logic        r_carry;
    logic        w_carry_nxt;
    logic        r_done;
    logic        w_done_nxt;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync2_d;
    logic        r_primed;
    logic        r_armed;

    logic        w_start_edge;
    logic        w_bit_end;
    logic [8:0]  w_sum;
    logic        w_tx;
    logic        w_busy;
    logic        w_unused;

    assign w_unused = ena;

    // A level already high at reset release must not count as an edge: the detector only
    // arms once a genuinely sampled low has been seen after reset.
    assign w_start_edge = r_armed & r_sync2 & ~r_sync2_d;
    assign w_bit_end    = (r_cnt == BIT_LAST);
    assign w_sum        = {1'b0, ui_in} + {2'b00, uio_in[6:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
            r_primed  <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_sync1   <= uio_in[7];
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            r_primed  <= 1'b1;
            r_armed   <= r_armed | (r_primed & ~r_sync1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_sum   <= w_sum_nxt;
            r_carry <= w_carry_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_sum_nxt   = r_sum;
        w_carry_nxt = r_carry;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (w_start_edge) begin
                    w_sum_nxt   = w_sum[7:0];
                    w_carry_nxt = w_sum[8];
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 12'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) begin
`ifdef SUMTX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 12'd1;
                end
            end
`ifdef SUMTX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 12'd1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 12'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START:  w_tx = 1'b0;
            S_DATA:   w_tx = r_sum[r_idx];
`ifdef SUMTX_PARITY_EN
            S_PARITY: w_tx = ^r_sum;
`endif
            default:  w_tx = 1'b1;
        endcase
    end

    assign w_busy  = (r_state != S_IDLE);
    assign uo_out  = {4'b0000, r_carry, r_done, w_busy, w_tx};
    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_c6_sum_uart_tx.sv
// Scoreboard bench for tt_c6_sum_uart_tx: stimulus pushes expected frames, a monitor decodes tx.
module tb_tt_c6_sum_uart_tx;

    localparam int CPB = 16;
`ifdef SUMTX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       carry;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic tx, busy, done, carry;
    assign tx    = uo_out[0];
    assign busy  = uo_out[1];
    assign done  = uo_out[2];
    assign carry = uo_out[3];

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;
    int   ndone = 0;
    int   frames_ok = 0;
    bit   mon_busy = 1'b0;

    tt_c6_sum_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    // Reference: the frame carries (A+B) mod 256; carry is whether A+B exceeds a byte.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   s;
        s       = a + b;
        e.data  = 8'(s % 256);
        e.carry = (s > 255);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [6:0] b, input bit lat);
        logic t2, t3;
        ui_in  = a;
        uio_in = {1'b0, b};
        tick(3);
        sb.push_back(model(int'(a), int'(b)));
        uio_in[7] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        t2 = tx;
        @(posedge clk);
        @(negedge clk);
        t3 = tx;
        if (lat) chk("start_latency", {30'd0, t2, t3}, 32'h2);
        @(posedge clk);
        #1;
        uio_in[7] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_busy || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {31'd0, n < 1000}, 32'd1);
    endtask

    initial begin : done_counter
        forever begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
    end

    initial begin : monitor
        logic        prev_tx;
        logic [10:0] bits;
        exp_t        e;
        bit          have, aborted, busy_bad, done_bad;
        logic        carry_seen;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_tx = 1'b1;
            end else begin
                if (prev_tx && !tx) begin
                    mon_busy = 1'b1;
                    have = (sb.size() != 0);
                    if (have) e = sb.pop_front();
                    else e = '0;
                    chk("frame_expected", {31'd0, have}, 32'd1);
                    carry_seen = carry;
                    aborted    = 1'b0;
                    busy_bad   = 1'b0;
                    done_bad   = 1'b0;
                    bits       = '0;
                    for (int k = 0; k < NBITS * CPB; k++) begin
                        if (k != 0) @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (!busy) busy_bad = 1'b1;
                        if (done) done_bad = 1'b1;
                        if (k % CPB == CPB / 2) bits[k / CPB] = tx;
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        if (!rst_n) aborted = 1'b1;
                    end
                    if (!aborted) begin
                        chk("start_bit", {31'd0, bits[0]}, 32'd0);
                        chk("data_byte", {24'd0, bits[8:1]}, {24'd0, e.data});
`ifdef SUMTX_PARITY_EN
                        chk("parity_bit", {31'd0, bits[9]}, {31'd0, ^e.data});
`endif
                        chk("stop_bit", {31'd0, bits[NBITS-1]}, 32'd1);
                        chk("carry", {31'd0, carry_seen}, {31'd0, e.carry});
                        chk("busy_in_frame", {31'd0, busy_bad}, 32'd0);
                        chk("no_early_done", {31'd0, done_bad}, 32'd0);
                        chk("done_at_frame_end", {30'd0, done, busy}, 32'h2);
                        frames_ok++;
                    end
                    mon_busy = 1'b0;
                end
                prev_tx = tx;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n0, g, n;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = '0;
        uio_in = '0;
        tick(3);
        chk("reset_uo_out", {24'd0, uo_out}, 32'h01);
        chk("reset_uio_out", {24'd0, uio_out}, 32'h00);
        chk("reset_uio_oe", {24'd0, uio_oe}, 32'h00);
        rst_n = 1'b1;
        tick(3);

        // Basic frame: 0x12 + 0x05 = 0x17
        send(8'h12, 7'h05, 1'b1);
        wait_idle();

        // Carry frame, then carry must hold without a new capture
        send(8'hFF, 7'h7F, 1'b1);
        wait_idle();
        ui_in  = 8'h01;
        uio_in = 8'h01;
        tick(20);
        chk("carry_held", {31'd0, carry}, 32'd1);

        // Second start pulse mid-frame is dropped
        n0 = ndone;
        send(8'h33, 7'h44, 1'b1);
        tick(48);
        uio_in[7] = 1'b1;
        tick(4);
        uio_in[7] = 1'b0;
        wait_idle();
        tick(10);
        chk("dropped_done_count", ndone - n0, 32'd1);

        // Reset mid-frame aborts without done
        n0 = ndone;
        send(8'h5A, 7'h21, 1'b0);
        tick(68);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_outputs", {28'd0, tx, busy, done, carry}, 32'h8);
        tick(2);
        rst_n = 1'b1;
        tick(30);
        chk("abort_no_done", ndone - n0, 32'd0);
        send(8'h80, 7'h01, 1'b1);
        wait_idle();

        // Start already high when reset releases must not launch a frame
        rst_n     = 1'b0;
        uio_in[7] = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(30);
        chk("no_frame_on_release", {30'd0, busy, tx}, 32'h1);
        uio_in[7] = 1'b0;
        tick(4);
        chk("quiet_after_release", {30'd0, busy, tx}, 32'h1);
`ifdef SUMTX_PARITY_EN
        send(8'h10, 7'h03, 1'b1);
        wait_idle();
`endif

        // Randomised frames with operand churn while in flight
        for (int i = 0; i < 8; i++) begin
            send(8'($urandom), 7'($urandom), 1'b1);
            for (int j = 0; j < 4; j++) begin
                tick($urandom_range(5, 30));
                ui_in       = 8'($urandom);
                uio_in[6:0] = 7'($urandom);
            end
            wait_idle();
        end

        // Back-to-back: start held across done, then low for one cycle and high again
        ui_in  = 8'hC3;
        uio_in = {1'b0, 7'h2C};
        tick(3);
        sb.push_back(model(8'hC3, 7'h2C));
        uio_in[7] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 400);
        chk("b2b_first_done", {31'd0, done}, 32'd1);
        ui_in  = 8'h0F;
        uio_in = {1'b0, 7'h70};
        sb.push_back(model(8'h0F, 7'h70));
        @(posedge clk);
        #1;
        uio_in[7] = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (tx && g < 20);
        chk("b2b_gap", {31'd0, g <= 4}, 32'd1);
        tick(2);
        uio_in[7] = 1'b0;
        wait_idle();

        tick(10);
        chk("frames_vs_done", ndone, frames_ok);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/tt_c6_sum_uart_tx.md
TT_C6_SUM_UART_TX -- requirements
Module: tt_c6_sum_uart_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the clock port SHALL be clk and the reset port SHALL be rst_n.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range 4..4095.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 ui_in  input  8  operand A.
REQ-006 uio_in  input  8  bits [6:0] are operand B; bit 7 is start, asynchronous to clk.
REQ-007 uo_out  output  8  bit 0 is tx (idle high); bit 1 is busy; bit 2 is done; bit 3 is carry; bits 7:4 are 0.
REQ-008 uio_out  output  8  constant 0.
REQ-009 uio_oe  output  8  constant 0 (all uio pins are inputs).
REQ-010 ena  input  1  ignored.

Function
REQ-011 Start SHALL pass through a 2-flop synchronizer; a rising edge is detected when the second stage is 1 and its previous value is 0.
REQ-012 States SHALL be IDLE, START, DATA, PARITY (present only with the macro), STOP.
REQ-013 In IDLE, a detected edge SHALL capture these values on the same clock edge:
- sum = A + zero-extended B, 9 bits, range 0..382;
- carry <= sum[8];
- FSM -> START.
REQ-014 tx SHALL go low after the 3rd rising clk edge at which uio_in[7] is sampled high.
REQ-015 Each bit SHALL last exactly CLKS_PER_BIT cycles, counted by an internal bit-timer that restarts at every state or bit change.
REQ-016 Frame order SHALL be: start bit (0), then sum[7:0] LSB first, then the parity bit if enabled, then one stop bit (1).
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 done SHALL be a 1-cycle pulse on the cycle the FSM returns from STOP to IDLE.
REQ-019 carry SHALL hold its captured value until the next capture.
REQ-020 Edges detected while busy SHALL be dropped, not queued.
REQ-021 An edge detected in the IDLE cycle that immediately follows done SHALL be accepted; back-to-back frames therefore have no idle gap beyond that cycle.
REQ-022 Operand changes after capture SHALL NOT affect the frame in flight.
REQ-023 Bit index SHALL run 0..7 with no wrap; DATA -> PARITY/STOP after index 7 completes.

Reset
REQ-024 On a clk edge with rst_n=0, the block SHALL reset as follows:
- FSM -> IDLE; tx=1, busy=0, done=0, carry=0;
- bit-timer, bit index and sum cleared;
- synchronizer flops cleared to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame: tx=1 from the next cycle and no done pulse.
REQ-026 A start level that is already high when reset releases SHALL NOT trigger a frame; a fresh 0->1 transition is required.

Configuration
REQ-027 Macro SUMTX_PARITY_EN defined: PARITY state present; one even-parity bit (XOR of sum[7:0]) is inserted between data and stop; frame = 11*CLKS_PER_BIT cycles.
REQ-028 Macro SUMTX_PARITY_EN undefined: no PARITY state and no parity logic; frame = 10*CLKS_PER_BIT cycles.

Verification
REQ-029 Basic frame (no parity, CLKS_PER_BIT=16): A=0x12, B=0x05, pulse start -> tx low after 3rd edge; bits 1,1,1,0,1,0,0,0; stop=1; carry=0; done pulses 160 cycles after tx falls.
REQ-030 Carry: A=0xFF, B=0x7F -> serialized byte 0x7E; carry=1 held until next capture.
REQ-031 Dropped start: second start pulse at cycle 50 of a frame -> no effect; exactly one done pulse.
REQ-032 Reset mid-frame: rst_n low at cycle 70 -> tx=1, busy=0 next cycle; no done; the next start produces a correct frame.
REQ-033 Parity with SUMTX_PARITY_EN: A=0x12, B=0x05 -> parity bit 0; A=0x10, B=0x03 (0x13) -> parity bit 1; frame = 176 cycles.
REQ-034 Back-to-back: start held high across done, then toggled low -> high -> second frame begins; the gap between stop end and next start bit is 4 cycles or fewer.
